// File: rtl/dcache_pkg.sv
// Shared types and address-field geometry for the direct-mapped data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    REFILL    = 2'd3
  } dc_state_t;

  localparam int unsigned DC_WORD_W   = 32;
  localparam int unsigned DC_OFFSET_W = 5;
  localparam int unsigned DC_INDEX_W  = 5;
  localparam int unsigned DC_TAG_W    = 32 - DC_INDEX_W - DC_OFFSET_W;
  localparam int unsigned DC_WSEL_LSB = 2;
  localparam int unsigned DC_WSEL_MSB = 4;
  localparam int unsigned DC_WSEL_W   = DC_WSEL_MSB - DC_WSEL_LSB + 1;

endpackage

// File: rtl/dcache_if.sv
// Pipeline-side and memory-side signals of the data cache controller.
interface dcache_if #(
  parameter int unsigned LINE_BITS = 256
);
  logic                 p1_req_i;
  logic                 p1_write_i;
  logic [31:0]          p1_addr_i;
  logic [31:0]          p1_data_i;
  logic [31:0]          p1_data_o;
  logic                 p1_stall_o;
  logic                 mem_enable_o;
  logic                 mem_write_o;
  logic [31:0]          mem_addr_o;
  logic [LINE_BITS-1:0] mem_data_o;
  logic [LINE_BITS-1:0] mem_data_i;
  logic                 mem_ack_i;

  // Controller side
  modport slave (
    input  p1_req_i, p1_write_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
    output p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  // Pipeline + memory environment side
  modport master (
    output p1_req_i, p1_write_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
    input  p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_storage.sv
// Tag/valid/dirty/data arrays: combinational read by index, one synchronous
// write port (full line refill or single-word merge), async clear of valid/dirty.
module dcache_storage
  import dcache_pkg::*;
#(
  parameter int unsigned LINES     = 32,
  parameter int unsigned LINE_BITS = 256,
  parameter int unsigned TAG_W     = 22,
  localparam int unsigned IDX_W    = $clog2(LINES),
  localparam int unsigned WORDS    = LINE_BITS / DC_WORD_W
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [IDX_W-1:0]     idx_i,
  output logic [TAG_W-1:0]     rd_tag_o,
  output logic                 rd_valid_o,
  output logic                 rd_dirty_o,
  output logic [LINE_BITS-1:0] rd_line_o,
  input  logic                 line_we_i,
  input  logic [TAG_W-1:0]     line_tag_i,
  input  logic [LINE_BITS-1:0] line_data_i,
  input  logic                 word_we_i,
  input  logic [DC_WSEL_W-1:0] word_sel_i,
  input  logic [DC_WORD_W-1:0] word_data_i
);

  logic [TAG_W-1:0]                    tag_q  [LINES];
  logic [WORDS-1:0][DC_WORD_W-1:0]     data_q [LINES];
  logic [LINES-1:0]                    valid_q;
  logic [LINES-1:0]                    dirty_q;

  assign rd_tag_o   = tag_q[idx_i];
  assign rd_valid_o = valid_q[idx_i];
  assign rd_dirty_o = dirty_q[idx_i];
  assign rd_line_o  = data_q[idx_i];

  // Tag and data payload: no reset, validity is tracked separately
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_q[idx_i]  <= line_tag_i;
      data_q[idx_i] <= line_data_i;
    end else if (word_we_i) begin
      data_q[idx_i][word_sel_i] <= word_data_i;
    end
  end

  // Valid/dirty bookkeeping: refill marks clean+valid, a merge marks dirty
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits finish in the access cycle; misses stall the pipeline until the line
// is resident, after which the held access is replayed as a hit.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int unsigned LINES     = 32,
  parameter int unsigned LINE_BITS = 256,
  parameter int unsigned TAG_W     = 22
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  dcache_if.slave  dc_if
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned WORDS = LINE_BITS / DC_WORD_W;

  dc_state_t                       state_q;
  logic                            req_sent_q;
  logic                            mem_enable_q;
  logic                            mem_write_q;
  logic [31:0]                     mem_addr_q;
  logic [LINE_BITS-1:0]            mem_data_q;
  logic [LINE_BITS-1:0]            refill_q;

  logic [IDX_W-1:0]                idx;
  logic [TAG_W-1:0]                tag;
  logic [DC_WSEL_W-1:0]            wsel;
  logic                            unused_addr_bits;

  logic [TAG_W-1:0]                st_tag;
  logic                            st_valid;
  logic                            st_dirty;
  logic [LINE_BITS-1:0]            st_line;
  logic [WORDS-1:0][DC_WORD_W-1:0] st_words;

  logic                            hit;
  logic                            miss;
  logic                            line_we;
  logic                            word_we;

  assign wsel             = dc_if.p1_addr_i[DC_WSEL_MSB:DC_WSEL_LSB];
  assign idx              = dc_if.p1_addr_i[DC_OFFSET_W +: IDX_W];
  assign tag              = dc_if.p1_addr_i[DC_OFFSET_W + IDX_W +: TAG_W];
  assign unused_addr_bits = ^dc_if.p1_addr_i[DC_WSEL_LSB-1:0];

  assign hit      = st_valid & (st_tag == tag);
  assign miss     = dc_if.p1_req_i & ~hit;
  assign st_words = st_line;

  // The pipeline holds addr/data stable while stalled, so the refill can use
  // the live address for its tag and the replayed store merges in IDLE.
  assign line_we = (state_q == REFILL);
  assign word_we = (state_q == IDLE) & dc_if.p1_req_i & dc_if.p1_write_i & hit;

  dcache_storage #(
    .LINES     (LINES),
    .LINE_BITS (LINE_BITS),
    .TAG_W     (TAG_W)
  ) u_storage (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .idx_i       (idx),
    .rd_tag_o    (st_tag),
    .rd_valid_o  (st_valid),
    .rd_dirty_o  (st_dirty),
    .rd_line_o   (st_line),
    .line_we_i   (line_we),
    .line_tag_i  (tag),
    .line_data_i (refill_q),
    .word_we_i   (word_we),
    .word_sel_i  (wsel),
    .word_data_i (dc_if.p1_data_i)
  );

  // Miss FSM with registered memory-side outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      req_sent_q   <= 1'b0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss) begin
            mem_enable_q <= 1'b1;
            if (st_valid && st_dirty) begin
              state_q     <= WRITEBACK;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {st_tag, idx, {DC_OFFSET_W{1'b0}}};
              req_sent_q  <= 1'b0;
            end else begin
              state_q     <= ALLOCATE;
              mem_write_q <= 1'b0;
              mem_addr_q  <= {tag, idx, {DC_OFFSET_W{1'b0}}};
              req_sent_q  <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (dc_if.mem_ack_i) begin
            state_q      <= ALLOCATE;
            mem_enable_q <= 1'b0;
            req_sent_q   <= 1'b0;
          end
        end
        // Entered from WRITEBACK with req_sent low: one enable-low cycle,
        // then issue the fetch and wait for its ack.
        ALLOCATE: begin
          if (!req_sent_q) begin
            mem_enable_q <= 1'b1;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= {tag, idx, {DC_OFFSET_W{1'b0}}};
            req_sent_q   <= 1'b1;
          end else if (dc_if.mem_ack_i) begin
            state_q      <= REFILL;
            mem_enable_q <= 1'b0;
            req_sent_q   <= 1'b0;
          end
        end
        REFILL: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Line-wide datapath registers: victim snapshot and fetched line
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && miss && st_valid && st_dirty) begin
      mem_data_q <= st_line;
    end
    if (state_q == ALLOCATE && req_sent_q && dc_if.mem_ack_i) begin
      refill_q <= dc_if.mem_data_i;
    end
  end

  assign dc_if.mem_enable_o = mem_enable_q;
  assign dc_if.mem_write_o  = mem_write_q;
  assign dc_if.mem_addr_o   = mem_addr_q;
  assign dc_if.mem_data_o   = mem_data_q;

  assign dc_if.p1_data_o  = (state_q == IDLE && dc_if.p1_req_i && hit) ? st_words[wsel] : '0;
  assign dc_if.p1_stall_o = rst_n_i & ((state_q != IDLE) | miss);

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a line-wide memory responder.
module tb_dcache_controller;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_if #(.LINE_BITS(256)) bus ();

  dcache_controller #(
    .LINES     (32),
    .LINE_BITS (256),
    .TAG_W     (22)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .dc_if   (bus)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // memory responder state
  int             ack_n     = 3;
  int             cyc       = 0;
  logic           ack_r     = 1'b0;
  logic           stray_ack = 1'b0;
  logic [255:0]   resp_data = '0;
  logic [255:0]   stray_data = '0;
  logic [255:0]   mem_model [int unsigned];
  logic [31:0]    log_addr [$];
  logic           log_wr   [$];
  logic [31:0]    log_w1   [$];
  int             log_start[$];
  int             log_ack  [$];

  assign bus.mem_ack_i  = ack_r | stray_ack;
  assign bus.mem_data_i = stray_ack ? stray_data : resp_data;

  function automatic logic [255:0] mk_line(input logic [31:0] base, input logic [31:0] w0);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = base + 32'(k);
    l[31:0] = w0;
    return l;
  endfunction

  task automatic clear_log();
    log_addr.delete(); log_wr.delete(); log_w1.delete();
    log_start.delete(); log_ack.delete();
  endtask

  // Acks during the ack_n-th cycle that enable is high
  initial begin
    int cnt = 0;
    int st  = 0;
    mem_model[32'h40]  = mk_line(32'h1000_0000, 32'hDEAD_BEEF);
    mem_model[32'h440] = mk_line(32'h2000_0000, 32'hA5A5_0000);
    mem_model[32'h80]  = mk_line(32'h8080_0000, 32'h8080_0000);
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        cnt = 0; ack_r = 1'b0;
      end else if (ack_r) begin
        ack_r = 1'b0; cnt = 0;
      end else if (bus.mem_enable_o) begin
        cnt++;
        if (cnt == 1) st = cyc;
        if (cnt >= ack_n) begin
          ack_r = 1'b1;
          log_addr.push_back(bus.mem_addr_o);
          log_wr.push_back(bus.mem_write_o);
          log_w1.push_back(bus.mem_data_o[63:32]);
          log_start.push_back(st);
          log_ack.push_back(cyc);
          if (bus.mem_write_o) mem_model[bus.mem_addr_o] = bus.mem_data_o;
          else resp_data = mem_model.exists(bus.mem_addr_o) ? mem_model[bus.mem_addr_o] : '0;
        end
      end
    end
  end

  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output int stalls, output logic [31:0] rdata);
    bit done = 1'b0;
    @(posedge clk); #1;
    bus.p1_req_i = 1'b1; bus.p1_write_i = wr; bus.p1_addr_i = addr; bus.p1_data_i = wdata;
    stalls = 0; rdata = '0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.p1_stall_o) stalls++;
      else begin rdata = bus.p1_data_o; done = 1'b1; end
    end
    check_eq("access_done", 64'(done), 64'd1);
    @(posedge clk); #1;
    bus.p1_req_i = 1'b0; bus.p1_write_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          st;
    logic [31:0] rd;
    bus.p1_req_i = 1'b0; bus.p1_write_i = 1'b0; bus.p1_addr_i = '0; bus.p1_data_i = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_enable", 64'(bus.mem_enable_o), 64'd0);
    check_eq("rst_write",  64'(bus.mem_write_o),  64'd0);
    check_eq("rst_addr",   64'(bus.mem_addr_o),   64'd0);
    check_eq("rst_pdata",  64'(bus.p1_data_o),    64'd0);
    bus.p1_req_i = 1'b1; bus.p1_addr_i = 32'h40; #1;
    check_eq("rst_stall_req", 64'(bus.p1_stall_o), 64'd0);
    bus.p1_req_i = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // cold read miss
    clear_log(); ack_n = 3;
    access(1'b0, 32'h40, '0, st, rd);
    check_eq("cold_stall", 64'(st), 64'd5);
    check_eq("cold_data",  64'(rd), 64'hDEAD_BEEF);
    check_eq("cold_ntx",   64'(log_addr.size()), 64'd1);
    if (log_addr.size() >= 1) begin
      check_eq("cold_addr", 64'(log_addr[0]), 64'h40);
      check_eq("cold_wr",   64'(log_wr[0]),   64'd0);
    end

    // write hit then read
    clear_log();
    access(1'b1, 32'h44, 32'h1234_5678, st, rd);
    check_eq("wh_stall", 64'(st), 64'd0);
    access(1'b0, 32'h44, '0, st, rd);
    check_eq("wh_rd_stall", 64'(st), 64'd0);
    check_eq("wh_rd_data",  64'(rd), 64'h1234_5678);
    access(1'b0, 32'h48, '0, st, rd);
    check_eq("wh_w2_data", 64'(rd), 64'h1000_0002);
    check_eq("wh_dirty2",  64'(dut.u_storage.dirty_q[2]), 64'd1);
    check_eq("wh_ntx",     64'(log_addr.size()), 64'd0);

    // dirty eviction
    clear_log(); ack_n = 3;
    access(1'b0, 32'h440, '0, st, rd);
    check_eq("ev_stall", 64'(st), 64'd9);
    check_eq("ev_data",  64'(rd), 64'hA5A5_0000);
    check_eq("ev_ntx",   64'(log_addr.size()), 64'd2);
    if (log_addr.size() >= 2) begin
      check_eq("ev_wb_wr",   64'(log_wr[0]),   64'd1);
      check_eq("ev_wb_addr", 64'(log_addr[0]), 64'h40);
      check_eq("ev_wb_w1",   64'(log_w1[0]),   64'h1234_5678);
      check_eq("ev_rd_wr",   64'(log_wr[1]),   64'd0);
      check_eq("ev_rd_addr", 64'(log_addr[1]), 64'h440);
      check_eq("ev_gap",     64'(log_start[1] - log_ack[0]), 64'd2);
    end
    check_eq("ev_dirty2", 64'(dut.u_storage.dirty_q[2]), 64'd0);

    // write miss allocate
    clear_log(); ack_n = 2;
    access(1'b1, 32'h80, 32'hCAFE_0001, st, rd);
    check_eq("wm_stall", 64'(st), 64'd4);
    check_eq("wm_ntx",   64'(log_addr.size()), 64'd1);
    if (log_addr.size() >= 1) begin
      check_eq("wm_addr", 64'(log_addr[0]), 64'h80);
      check_eq("wm_wr",   64'(log_wr[0]),   64'd0);
    end
    access(1'b0, 32'h80, '0, st, rd);
    check_eq("wm_rd_stall", 64'(st), 64'd0);
    check_eq("wm_rd_data",  64'(rd), 64'hCAFE_0001);
    access(1'b0, 32'h84, '0, st, rd);
    check_eq("wm_w1_data", 64'(rd), 64'h8080_0001);
    check_eq("wm_dirty4",  64'(dut.u_storage.dirty_q[4]), 64'd1);

    // reset mid-ALLOCATE
    ack_n = 10;
    @(posedge clk); #1;
    bus.p1_req_i = 1'b1; bus.p1_write_i = 1'b0; bus.p1_addr_i = 32'h40;
    @(negedge clk);
    check_eq("ra_miss_stall", 64'(bus.p1_stall_o), 64'd1);
    @(negedge clk);
    check_eq("ra_enable", 64'(bus.mem_enable_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ra_rst_enable", 64'(bus.mem_enable_o), 64'd0);
    check_eq("ra_rst_stall",  64'(bus.p1_stall_o),   64'd0);
    check_eq("ra_rst_addr",   64'(bus.mem_addr_o),   64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    bus.p1_req_i = 1'b0; rst_n = 1'b1; ack_n = 3;
    clear_log();
    access(1'b0, 32'h80, '0, st, rd);
    check_eq("ra_80_stall", 64'(st), 64'd5);
    check_eq("ra_80_data",  64'(rd), 64'h8080_0000);
    check_eq("ra_80_ntx",   64'(log_addr.size()), 64'd1);
    access(1'b0, 32'h40, '0, st, rd);
    check_eq("ra_40_stall", 64'(st), 64'd5);
    check_eq("ra_40_data",  64'(rd), 64'hDEAD_BEEF);
    access(1'b0, 32'h44, '0, st, rd);
    check_eq("ra_44_data",  64'(rd), 64'h1234_5678);

    // stray ack in IDLE
    clear_log();
    @(negedge clk);
    stray_data = '1; stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    check_eq("sa_enable", 64'(bus.mem_enable_o), 64'd0);
    check_eq("sa_stall",  64'(bus.p1_stall_o),   64'd0);
    access(1'b0, 32'h40, '0, st, rd);
    check_eq("sa_stall_rd", 64'(st), 64'd0);
    check_eq("sa_data",     64'(rd), 64'hDEAD_BEEF);
    check_eq("sa_dirty2",   64'(dut.u_storage.dirty_q[2]), 64'd0);
    check_eq("sa_ntx",      64'(log_addr.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
